peripheral_bus: RTL and testbench
=================================

Name: peripheral_bus

Overview:
- Memory-mapped I/O slave on the CPU data bus; decodes the 0x40000000 page and serves loads/stores not handled by data memory.
- Holds the programmable timer, LED register, switch input and 7-segment register.
- Drives the CPU interrupt request from the timer.
- Sits downstream of the CPU ALU address / DatabusB store path, in parallel with data memory; its read data is muxed into the load-data path.

Parameters:
- BASE, 32'h40000000, page base of the peripheral window (addr[31:8] compared against BASE[31:8]).
- LED_W, 8, width of LED register and led port.
- SW_W, 8, width of switch input.
- DIGI_W, 12, width of digit register and digi port.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- rd  input  1  load strobe (MemRd).
- wr  input  1  store strobe (MemWr).
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data (DatabusB).
- rdata  output  32  load data, combinational.
- switch  input  SW_W  board switches, sampled by a 2-flop synchronizer.
- led  output  LED_W  LED register.
- digi  output  DIGI_W  7-segment register: [11:8] anode select (active-low), [7:0] segments.
- irqout  output  1  interrupt request to Control IRQ.

Behaviour:
- Register map, word offsets; addr[1:0] ignored:
  - 0x00 TH: 32-bit reload value, R/W.
  - 0x04 TL: 32-bit counter, R/W.
  - 0x08 TCON[2:0]: bit0 enable, bit1 irq-enable, bit2 irq-status. R/W; reads return zero in [31:3].
  - 0x0C LED[LED_W-1:0], R/W.
  - 0x10 SWITCH: synchronized value, read-only; writes ignored.
  - 0x14 DIGI[DIGI_W-1:0], R/W.
- Offsets 0x18-0xFC, and any address outside the page: rdata = 0, writes ignored.
- Reads:
  - rdata = selected register, zero-extended, when rd = 1 and the address hits the page.
  - rdata = 0 otherwise, including when rd = 0.
  - Zero latency; combinational from addr and current register state.
- Writes: take effect on the rising clk edge where wr = 1 and the address hits; new value is visible to a read in the next cycle.
- Reset: TH, TL, TCON, LED, DIGI and both switch sync flops clear to 0. Hence led = 0, digi = 0, irqout = 0, rdata = 0.
  - A reset asserted mid-count clears TL and TCON on that edge; no interrupt is produced.
- Timer, each edge with TCON[0] = 1:
  - TL != 32'hFFFFFFFF: TL <= TL + 1.
  - TL == 32'hFFFFFFFF: TL <= TH, and if TCON[1] = 1 then TCON[2] <= 1.
  - Wrap period is therefore (2^32 - TH) cycles.
- TCON[0] = 0: TL holds.
- TCON[2] is sticky; it clears only by a software write of 0 to bit2 or by reset.
- Collisions on the same edge:
  - Store to TL while counting: written value wins; no increment that cycle.
  - Store to TCON on the overflow edge: the overflow set of bit2 has priority over a written 0 in bit2; other bits take the written value.
  - Store to TH on the overflow edge: TL reloads from the old TH.
- irqout = TCON[1] & TCON[2], combinational from registers.
  - Stays high until software clears it; the CPU handler must clear bit1 or bit2 to avoid re-entry.
- Simultaneous rd and wr to the same register: rdata shows the pre-write value.
- Switch path: switch -> sync1 -> sync2; reads return sync2, giving 2-cycle latency from a pin change.

Decomposition:
- Shared package holds:
  - Address offsets: OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_SW, OFF_DIGI.
  - TCON bit indices: TCON_EN = 0, TCON_IE = 1, TCON_IS = 2.
  - Peripheral base constant 32'h40000000, also used by the CPU for the data-memory / peripheral read mux select.
- One natural sub-module: peri_timer.
  - Contains TH, TL, TCON, overflow and irqout.
  - Has a write port with per-register write enables.
- Address decode, LED, DIGI and switch sync stay in the top.

Test Plan:
- Reset, then read every offset -> rdata = 0; led = 0, digi = 0, irqout = 0.
- Write TH = 32'hFFFFFFFC, TL = 32'hFFFFFFFE, TCON = 3'b011 -> TL reads FFFFFFFF after 1 edge; next edge TL = FFFFFFFC, TCON reads 3'b111, irqout = 1.
- Let timer run from the previous state -> irqout stays 1 across further wraps; write TCON = 3'b001 -> irqout = 0 next cycle, TL keeps counting.
- Write TCON = 3'b010 on the exact overflow edge -> TCON reads 3'b110 (status set wins); TL = TH.
- Write LED = 32'h000001A5 and DIGI = 32'h00000E3F -> led = 8'hA5, digi = 12'hE3F; readback 32'hA5 and 32'hE3F.
- Drive switch = 8'h5A -> read 0x10 returns 32'h5A from the 2nd edge on; write 0x10 has no effect.
- Read 0x40000018 and 0x00000010 -> rdata = 0.
- Assert reset while TL is counting -> TL = 0, TCON = 0, irqout = 0.

Source files
------------

// File: rtl/peripheral_bus_pkg.sv
// Shared constants for the memory-mapped peripheral page: base address,
// register offsets and timer control bit positions.
package peripheral_bus_pkg;

    localparam logic [31:0] PERI_BASE = 32'h40000000;

    localparam logic [7:0] OFF_TH   = 8'h00;
    localparam logic [7:0] OFF_TL   = 8'h04;
    localparam logic [7:0] OFF_TCON = 8'h08;
    localparam logic [7:0] OFF_LED  = 8'h0C;
    localparam logic [7:0] OFF_SW   = 8'h10;
    localparam logic [7:0] OFF_DIGI = 8'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    // The CPU reuses this to steer load data between data memory and peripherals.
    function automatic logic page_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:8] == base[31:8];
    endfunction

endpackage

// File: rtl/peripheral_bus_if.sv
// Load/store bus between the CPU data path and the peripheral page.
interface peripheral_bus_if;

    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);

endinterface

// File: rtl/peripheral_bus_timer.sv
// Programmable reload timer (TH/TL/TCON) with a sticky overflow status
// that drives the CPU interrupt request.
module peri_timer
    import peripheral_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        th_we,
    input  logic        tl_we,
    input  logic        tcon_we,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irqout
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        overflow;

    always_comb begin
        overflow = tcon_q[TCON_EN] && (tl_q == 32'hFFFFFFFF);

        th_d = th_we ? wdata : th_q;

        // Reload uses the TH value held before this edge, even if TH is being written.
        tl_d = tl_q;
        if (tl_we) begin
            tl_d = wdata;
        end else if (overflow) begin
            tl_d = th_q;
        end else if (tcon_q[TCON_EN]) begin
            tl_d = tl_q + 32'd1;
        end

        // A hardware status set outranks a software clear landing on the same edge.
        tcon_d = tcon_we ? wdata[2:0] : tcon_q;
        if (overflow && tcon_q[TCON_IE]) begin
            tcon_d[TCON_IS] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    assign th     = th_q;
    assign tl     = tl_q;
    assign tcon   = tcon_q;
    assign irqout = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule

// File: rtl/peripheral_bus.sv
// Peripheral page slave: address decode, LED/digit registers, switch
// synchronizer and the timer, with zero-latency read data.
module peripheral_bus
    import peripheral_bus_pkg::*;
#(
    parameter logic [31:0] BASE   = PERI_BASE,
    parameter int          LED_W  = 8,
    parameter int          SW_W   = 8,
    parameter int          DIGI_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    peripheral_bus_if.slave    bus,
    input  logic [SW_W-1:0]    switch,
    output logic [LED_W-1:0]   led,
    output logic [DIGI_W-1:0]  digi,
    output logic               irqout
);

    logic                hit;
    logic [7:0]          off;
    logic                wr_hit;
    logic [LED_W-1:0]    led_q, led_d;
    logic [DIGI_W-1:0]   digi_q, digi_d;
    logic [SW_W-1:0]     sync1_q, sync1_d;
    logic [SW_W-1:0]     sync2_q, sync2_d;
    logic [31:0]         th, tl;
    logic [2:0]          tcon;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^bus.addr[1:0];

    always_comb begin
        hit    = page_hit(bus.addr, BASE);
        off    = {bus.addr[7:2], 2'b00};
        wr_hit = bus.wr && hit;

        led_d = led_q;
        if (wr_hit && off == OFF_LED) begin
            led_d = bus.wdata[LED_W-1:0];
        end
        digi_d = digi_q;
        if (wr_hit && off == OFF_DIGI) begin
            digi_d = bus.wdata[DIGI_W-1:0];
        end
        sync1_d = switch;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q   <= '0;
            digi_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            led_q   <= led_d;
            digi_q  <= digi_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    peri_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .th_we   (wr_hit && off == OFF_TH),
        .tl_we   (wr_hit && off == OFF_TL),
        .tcon_we (wr_hit && off == OFF_TCON),
        .wdata   (bus.wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irqout  (irqout)
    );

    // Reads see pre-write register state, so a same-cycle rd+wr returns the old value.
    always_comb begin
        bus.rdata = '0;
        if (bus.rd && hit) begin
            case (off)
                OFF_TH:   bus.rdata = th;
                OFF_TL:   bus.rdata = tl;
                OFF_TCON: bus.rdata = {29'd0, tcon};
                OFF_LED:  bus.rdata = 32'(led_q);
                OFF_SW:   bus.rdata = 32'(sync2_q);
                OFF_DIGI: bus.rdata = 32'(digi_q);
                default:  bus.rdata = '0;
            endcase
        end
    end

    assign led  = led_q;
    assign digi = digi_q;

endmodule

// File: tb/tb_peripheral_bus.sv
// Directed bench for peripheral_bus: table of single-cycle bus vectors plus
// hand-written timer, switch and reset sequences.
module tb_peripheral_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  switch;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;
    int          n_applied = 0;
    int          n_fail = 0;

    peripheral_bus_if bus ();

    peripheral_bus dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .switch (switch),
        .led    (led),
        .digi   (digi),
        .irqout (irqout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_led;
        logic [11:0] exp_digi;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [19];

    localparam logic [31:0] A_TH   = 32'h40000000;
    localparam logic [31:0] A_TL   = 32'h40000004;
    localparam logic [31:0] A_TCON = 32'h40000008;
    localparam logic [31:0] A_LED  = 32'h4000000C;
    localparam logic [31:0] A_SW   = 32'h40000010;
    localparam logic [31:0] A_DIGI = 32'h40000014;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_applied++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic stepClk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        bus.rd    = v.rd;
        bus.wr    = v.wr;
        bus.addr  = v.addr;
        bus.wdata = v.wdata;
        #1;
        checkOutput($sformatf("vec%0d rdata", idx), bus.rdata, v.exp_rdata);
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        checkOutput($sformatf("vec%0d led", idx), 32'(led), 32'(v.exp_led));
        checkOutput($sformatf("vec%0d digi", idx), 32'(digi), 32'(v.exp_digi));
        checkOutput($sformatf("vec%0d irq", idx), 32'(irqout), 32'(v.exp_irq));
    endtask

    task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] expected);
        bus.rd   = 1'b1;
        bus.addr = a;
        #1;
        checkOutput(name, bus.rdata, expected);
        bus.rd = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, A_TH,          32'h0,   32'h0,   8'h00, 12'h000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, A_TL,          32'h0,   32'h0,   8'h00, 12'h000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, A_TCON,        32'h0,   32'h0,   8'h00, 12'h000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, A_LED,         32'h0,   32'h0,   8'h00, 12'h000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, A_SW,          32'h0,   32'h0,   8'h00, 12'h000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, A_DIGI,        32'h0,   32'h0,   8'h00, 12'h000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h40000018,  32'h0,   32'h0,   8'h00, 12'h000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h400000FC,  32'h0,   32'h0,   8'h00, 12'h000, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, A_LED,         32'h1A5, 32'h0,   8'hA5, 12'h000, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, A_DIGI,        32'hE3F, 32'h0,   8'hA5, 12'hE3F, 1'b0};
        vecs[10] = '{1'b1, 1'b0, A_LED,         32'h0,   32'hA5,  8'hA5, 12'hE3F, 1'b0};
        vecs[11] = '{1'b1, 1'b0, A_DIGI,        32'h0,   32'hE3F, 8'hA5, 12'hE3F, 1'b0};
        vecs[12] = '{1'b1, 1'b1, A_LED,         32'h3C,  32'hA5,  8'h3C, 12'hE3F, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h0000000C,  32'hFF,  32'h0,   8'h3C, 12'hE3F, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h0000000C,  32'h0,   32'h0,   8'h3C, 12'hE3F, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 32'h00000010,  32'h0,   32'h0,   8'h3C, 12'hE3F, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 32'h4000001C,  32'hFF,  32'h0,   8'h3C, 12'hE3F, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 32'h4000000F,  32'h0,   32'h3C,  8'h3C, 12'hE3F, 1'b0};
        vecs[18] = '{1'b0, 1'b0, A_LED,         32'h0,   32'h0,   8'h3C, 12'hE3F, 1'b0};

        reset     = 1'b1;
        switch    = 8'h00;
        bus.rd    = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        stepClk(2);
        reset = 1'b0;

        checkOutput("reset led", 32'(led), 32'h0);
        checkOutput("reset digi", 32'(digi), 32'h0);
        checkOutput("reset irq", 32'(irqout), 32'h0);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Timer: first overflow with interrupt enabled.
        writeReg(A_TH, 32'hFFFFFFFC);
        writeReg(A_TL, 32'hFFFFFFFE);
        writeReg(A_TCON, 32'h3);
        readCheck("tl after enable", A_TL, 32'hFFFFFFFE);
        readCheck("tcon after enable", A_TCON, 32'h3);
        checkOutput("irq before wrap", 32'(irqout), 32'h0);
        stepClk(1);
        readCheck("tl at max", A_TL, 32'hFFFFFFFF);
        stepClk(1);
        readCheck("tl reload", A_TL, 32'hFFFFFFFC);
        readCheck("tcon status set", A_TCON, 32'h7);
        checkOutput("irq after wrap", 32'(irqout), 32'h1);
        readCheck("th readback", A_TH, 32'hFFFFFFFC);

        stepClk(4);
        readCheck("tl second wrap", A_TL, 32'hFFFFFFFC);
        checkOutput("irq sticky", 32'(irqout), 32'h1);

        writeReg(A_TCON, 32'h1);
        readCheck("tcon cleared", A_TCON, 32'h1);
        checkOutput("irq cleared", 32'(irqout), 32'h0);
        readCheck("tl keeps counting", A_TL, 32'hFFFFFFFD);

        // Software clear on the overflow edge loses to the status set.
        writeReg(A_TCON, 32'h3);
        stepClk(1);
        readCheck("tl pre-collision", A_TL, 32'hFFFFFFFF);
        writeReg(A_TCON, 32'h2);
        readCheck("tcon collision", A_TCON, 32'h6);
        readCheck("tl collision reload", A_TL, 32'hFFFFFFFC);
        checkOutput("irq collision", 32'(irqout), 32'h1);
        stepClk(2);
        readCheck("tl held disabled", A_TL, 32'hFFFFFFFC);

        // TL store wins over increment.
        writeReg(A_TCON, 32'h1);
        writeReg(A_TL, 32'h100);
        readCheck("tl store wins", A_TL, 32'h100);
        stepClk(1);
        readCheck("tl increments", A_TL, 32'h101);

        // TH store on overflow edge: reload uses old TH.
        writeReg(A_TL, 32'hFFFFFFFF);
        writeReg(A_TH, 32'h10);
        readCheck("tl reload old th", A_TL, 32'hFFFFFFFC);
        readCheck("th new value", A_TH, 32'h10);
        readCheck("tcon no status when ie=0", A_TCON, 32'h1);
        checkOutput("irq ie=0", 32'(irqout), 32'h0);

        writeReg(A_TCON, 32'h7);
        checkOutput("irq sw set", 32'(irqout), 32'h1);

        // Switch synchronizer latency and read-only behaviour.
        switch = 8'h5A;
        readCheck("sw latency 0", A_SW, 32'h0);
        stepClk(1);
        readCheck("sw latency 1", A_SW, 32'h0);
        stepClk(1);
        readCheck("sw latency 2", A_SW, 32'h5A);
        writeReg(A_SW, 32'h0);
        readCheck("sw write ignored", A_SW, 32'h5A);
        checkOutput("irq before reset", 32'(irqout), 32'h1);

        // Reset while counting.
        reset = 1'b1;
        stepClk(1);
        reset = 1'b0;
        readCheck("reset tl", A_TL, 32'h0);
        readCheck("reset th", A_TH, 32'h0);
        readCheck("reset tcon", A_TCON, 32'h0);
        readCheck("reset sw", A_SW, 32'h0);
        checkOutput("reset irq mid", 32'(irqout), 32'h0);
        checkOutput("reset led mid", 32'(led), 32'h0);
        checkOutput("reset digi mid", 32'(digi), 32'h0);
        stepClk(2);
        readCheck("tl idle after reset", A_TL, 32'h0);
        readCheck("sw after reset", A_SW, 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule
